// File: rtl/axi_simple_master.sv
// Single-outstanding AXI4 initiator: one-beat reads/writes from a valid/ready req/rsp port.
// Ports: clk, rst (sync, active-high); req_* request in; rsp_* response out; axi_mosi/axi_miso bus.
package utils_pkg;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic [3:0]  awqos;
        logic [3:0]  awregion;
        logic        awuser;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wuser;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic [3:0]  arqos;
        logic [3:0]  arregion;
        logic        aruser;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        buser;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        ruser;
        logic        rvalid;
    } s_axi_miso_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

module axi_simple_master
    import utils_pkg::*;
#(
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output s_axi_mosi_t axi_mosi,
    input  s_axi_miso_t axi_miso
);

    typedef enum logic [2:0] {
        IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, RSP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_timer;
    logic [2:0]  r_size;
    logic [3:0]  r_wstrb;
    logic        r_err;
    logic        r_timeout;

    logic w_accept;
    logic w_wait;
    logic w_hs;
    logic w_expire;
    logic w_abort;
    logic w_drain;
    logic w_unused;

    // IDs, user bits and rlast carry nothing for single-beat, single-ID traffic.
    assign w_unused = &{1'b0, axi_miso.bid, axi_miso.buser, axi_miso.rid,
                        axi_miso.rlast, axi_miso.ruser};

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_wait   = r_state inside {WR_AW, WR_W, WR_B, RD_AR, RD_R};

    // Our own valid/ready is always high in a wait state, so the
    // handshake reduces to the slave's side.
    always_comb begin
        w_hs = 1'b0;
        unique case (r_state)
            WR_AW:   w_hs = axi_miso.awready;
            WR_W:    w_hs = axi_miso.wready;
            WR_B:    w_hs = axi_miso.bvalid;
            RD_AR:   w_hs = axi_miso.arready;
            RD_R:    w_hs = axi_miso.rvalid;
            default: w_hs = 1'b0;
        endcase
    end

    assign w_expire = (TIMEOUT_CYCLES != 0) && w_wait &&
                      (r_timer == TIMEOUT_CYCLES - 1);
    // A handshake landing on the last allowed cycle still wins.
    assign w_abort  = w_expire && !w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_we ? WR_AW : RD_AR;
                end
            end
            WR_AW:   if (w_hs) w_next = WR_W;
            WR_W:    if (w_hs) w_next = WR_B;
            WR_B:    if (w_hs) w_next = RSP;
            RD_AR:   if (w_hs) w_next = RD_R;
            RD_R:    if (w_hs) w_next = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = RSP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_timer   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= req_addr;
                r_size    <= req_size;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_timer   <= '0;
                r_rdata   <= '0;
                r_err     <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_wait) begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_abort) begin
                r_rdata   <= '0;
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
            end else if (r_state == WR_B && axi_miso.bvalid) begin
                r_err <= (axi_miso.bresp != AXI_RESP_OKAY);
            end else if (r_state == RD_R && axi_miso.rvalid) begin
                r_rdata <= axi_miso.rdata;
                r_err   <= (axi_miso.rresp != AXI_RESP_OKAY);
            end
        end
    end

    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_timeout;

    // Outside a transaction we keep accepting B/R so stray or late
    // responses are swallowed instead of stalling the fabric.
    assign w_drain = (r_state == IDLE) || (r_state == RSP);

    always_comb begin
        axi_mosi         = '0;
        axi_mosi.awid    = 4'(AXI_ID);
        axi_mosi.awaddr  = r_addr;
        axi_mosi.awsize  = r_size;
        axi_mosi.awburst = AXI_BURST_INCR;
        axi_mosi.awvalid = (r_state == WR_AW);
        axi_mosi.wdata   = r_wdata;
        axi_mosi.wstrb   = r_wstrb;
        axi_mosi.wvalid  = (r_state == WR_W);
        axi_mosi.wlast   = (r_state == WR_W);
        axi_mosi.bready  = !rst && (w_drain || r_state == WR_B);
        axi_mosi.arid    = 4'(AXI_ID);
        axi_mosi.araddr  = r_addr;
        axi_mosi.arsize  = r_size;
        axi_mosi.arburst = AXI_BURST_INCR;
        axi_mosi.arvalid = (r_state == RD_AR);
        axi_mosi.rready  = !rst && (w_drain || r_state == RD_R);
    end

endmodule

// File: tb/tb_axi_simple_master.sv
// Bench for axi_simple_master: configurable AXI slave stub, memory reference
// model, directed scenarios followed by a randomized read/write mix.
module tb_axi_simple_master;
    import utils_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_tmo;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_tmo;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    s_axi_mosi_t mosi_a, mosi_b, m;
    s_axi_miso_t s, miso_a, miso_b;

    logic        q_req_ready, q_rsp_valid, q_rsp_err, q_rsp_tmo;
    logic [31:0] q_rsp_rdata;

    assign m           = sel ? mosi_b : mosi_a;
    assign miso_a      = sel ? s_axi_miso_t'('0) : s;
    assign miso_b      = sel ? s : s_axi_miso_t'('0);
    assign q_req_ready = sel ? b_req_ready : a_req_ready;
    assign q_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign q_rsp_err   = sel ? b_rsp_err : a_rsp_err;
    assign q_rsp_tmo   = sel ? b_rsp_tmo : a_rsp_tmo;
    assign q_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    axi_simple_master #(.AXI_ID(0), .TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .rsp_timeout(a_rsp_tmo),
        .axi_mosi(mosi_a), .axi_miso(miso_a)
    );

    axi_simple_master #(.AXI_ID(0), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_timeout(b_rsp_tmo),
        .axi_mosi(mosi_b), .axi_miso(miso_b)
    );

    // ---------------- slave stub ----------------
    bit          stub_rst;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          ar_never;
    bit          rforce;
    logic [31:0] rforce_val;
    logic [1:0]  bresp_cfg, rresp_cfg;

    int          aw_w, w_w, b_w, ar_w, r_w;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          b_pend, r_pend;
    logic [31:0] aw_q, rdq;
    logic [31:0] smem [0:255];

    always_comb begin
        s         = '0;
        s.awready = m.awvalid && (aw_w >= aw_dly);
        s.wready  = m.wvalid && (w_w >= w_dly);
        s.bvalid  = b_pend && (b_w >= b_dly);
        s.bresp   = s.bvalid ? bresp_cfg : 2'b00;
        s.arready = m.arvalid && !ar_never && (ar_w >= ar_dly);
        s.rvalid  = r_pend && (r_w >= r_dly);
        s.rdata   = s.rvalid ? rdq : 32'h0;
        s.rresp   = s.rvalid ? rresp_cfg : 2'b00;
        s.rlast   = s.rvalid;
    end

    always @(posedge clk) begin
        if (stub_rst) begin
            for (int i = 0; i < 256; i++) smem[i] <= '0;
            aw_w <= 0; w_w <= 0; b_w <= 0; ar_w <= 0; r_w <= 0;
            aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; r_hs <= 0;
            b_pend <= 1'b0; r_pend <= 1'b0; aw_q <= '0; rdq <= '0;
        end else begin
            if (m.awvalid) begin
                if (s.awready) begin
                    aw_w <= 0; aw_q <= m.awaddr; aw_hs <= aw_hs + 1;
                end else aw_w <= aw_w + 1;
            end else aw_w <= 0;
            if (s.bvalid && m.bready) begin
                b_pend <= 1'b0; b_hs <= b_hs + 1;
            end else if (b_pend && !s.bvalid) b_w <= b_w + 1;
            if (m.wvalid) begin
                if (s.wready) begin
                    w_w <= 0; w_hs <= w_hs + 1;
                    for (int i = 0; i < 4; i++)
                        if (m.wstrb[i])
                            smem[aw_q[9:2]][8*i +: 8] <= m.wdata[8*i +: 8];
                    b_pend <= 1'b1; b_w <= 0;
                end else w_w <= w_w + 1;
            end else w_w <= 0;
            if (s.rvalid && m.rready) begin
                r_pend <= 1'b0; r_hs <= r_hs + 1;
            end else if (r_pend && !s.rvalid) r_w <= r_w + 1;
            if (m.arvalid) begin
                if (s.arready) begin
                    ar_w <= 0; ar_hs <= ar_hs + 1;
                    r_pend <= 1'b1; r_w <= 0;
                    rdq <= rforce ? rforce_val : smem[m.araddr[9:2]];
                end else ar_w <= ar_w + 1;
            end else ar_w <= 0;
        end
    end

    // ---------------- reference model + checking ----------------
    logic [31:0] model [0:255];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st);
        for (int i = 0; i < 4; i++)
            if (st[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    // Issue one request and wait for its response. Index 0 is the first
    // negedge after acceptance; returns at the negedge rsp_valid is seen.
    task automatic txn(input bit we, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic [3:0] st, input bit watch,
                       output logic [31:0] rd, output logic err,
                       output logic tmo, output int ar_rise,
                       output int rsp_at, output int aw_at,
                       output int w_first);
        int  n;
        bit  seen;
        ar_rise = -1; rsp_at = -1; aw_at = -1; w_first = -1;
        rd = 'x; err = 'x; tmo = 'x;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_wdata = wd; req_wstrb = st;
        n = 0;
        while (!q_req_ready && n < 200) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 2000 && !seen) begin
            if (q_rsp_valid) begin
                seen = 1'b1; rsp_at = n;
                rd = q_rsp_rdata; err = q_rsp_err; tmo = q_rsp_tmo;
            end else begin
                if (m.arvalid && ar_rise < 0) ar_rise = n;
                if (m.awvalid && s.awready) aw_at = n;
                if (m.wvalid && w_first < 0) w_first = n;
                if (watch) begin
                    chk("aw_w_overlap", 32'(m.awvalid && m.wvalid), 0);
                    if (m.awvalid) begin
                        chk("awaddr_stable", m.awaddr, a);
                        chk("awsize", 32'(m.awsize), 32'(sz));
                    end
                    if (m.wvalid) begin
                        chk("wdata_stable", m.wdata, wd);
                        chk("wstrb_stable", 32'(m.wstrb), 32'(st));
                        chk("wlast", 32'(m.wlast), 1);
                    end
                end
                @(negedge clk); n++;
            end
        end
        if (!seen) chk("rsp_wait_expired", 0, 1);
        if (we && seen && !tmo) chk("w_after_aw", w_first, aw_at + 1);
    endtask

    initial begin
        logic [31:0] rd, wd, a, hold;
        logic        err, tmo;
        logic [3:0]  st;
        bit          we, any_rsp;
        int          ar_r, rsp_at, aw_at, w_f, h_aw, h_w, h_b, n;

        sel = 1'b0; rst = 1'b1; stub_rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        ar_never = 1'b0; rforce = 1'b0; rforce_val = '0;
        bresp_cfg = AXI_RESP_OKAY; rresp_cfg = AXI_RESP_OKAY;
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(q_req_ready), 1);
        chk("rst_rsp_valid", 32'(q_rsp_valid), 0);
        chk("rst_rsp_rdata", q_rsp_rdata, 0);
        chk("rst_rsp_err", 32'(q_rsp_err), 0);
        chk("rst_rsp_tmo", 32'(q_rsp_tmo), 0);
        chk("rst_valids", 32'({m.awvalid, m.wvalid, m.arvalid}), 0);
        chk("rst_readies", 32'({m.bready, m.rready}), 0);
        rst = 1'b0; stub_rst = 1'b0;
        @(negedge clk);
        chk("idle_bready", 32'(m.bready), 1);

        // full-word write then read back
        txn(1, 32'h100, 3'd2, 32'hDEADBEEF, 4'hF, 0,
            rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        mdl_write(32'h100, 32'hDEADBEEF, 4'hF);
        chk("wr1_err", 32'(err), 0);
        chk("wr1_rdata", rd, 0);
        txn(0, 32'h100, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("rd1_err", 32'(err), 0);
        chk("rd1_data", rd, model[8'h40]);

        // single byte lane write
        txn(1, 32'h103, 3'd0, 32'hAB000000, 4'h8, 0,
            rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        mdl_write(32'h103, 32'hAB000000, 4'h8);
        chk("wrb_err", 32'(err), 0);
        txn(0, 32'h100, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("rdb_data", rd, 32'hABADBEEF);
        chk("rdb_model", rd, model[8'h40]);

        // backpressure on every write channel
        aw_dly = 5; w_dly = 3; b_dly = 4;
        h_aw = aw_hs; h_w = w_hs; h_b = b_hs;
        wd = $urandom;
        txn(1, 32'h40, 3'd2, wd, 4'hF, 1, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        mdl_write(32'h40, wd, 4'hF);
        chk("bp_err", 32'(err), 0);
        chk("bp_aw_count", aw_hs - h_aw, 1);
        chk("bp_w_count", w_hs - h_w, 1);
        chk("bp_b_count", b_hs - h_b, 1);
        aw_dly = 0; w_dly = 0; b_dly = 0;
        txn(0, 32'h40, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("bp_readback", rd, model[8'h10]);

        // error responses
        bresp_cfg = AXI_RESP_SLVERR;
        txn(1, 32'h300, 3'd2, 32'h5555AAAA, 4'hF, 0,
            rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("slverr_err", 32'(err), 1);
        chk("slverr_tmo", 32'(tmo), 0);
        bresp_cfg = AXI_RESP_OKAY;
        rresp_cfg = AXI_RESP_DECERR; rforce = 1'b1; rforce_val = 32'h1234;
        txn(0, 32'h300, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("decerr_err", 32'(err), 1);
        chk("decerr_rdata", rd, 32'h1234);
        rresp_cfg = AXI_RESP_OKAY; rforce = 1'b0;

        // watchdog on the short-timeout instance
        sel = 1'b1; ar_never = 1'b1;
        @(negedge clk);
        txn(0, 32'h20, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("to_err", 32'(err), 1);
        chk("to_flag", 32'(tmo), 1);
        chk("to_rdata", rd, 0);
        chk("to_latency", rsp_at - ar_r, 8);
        chk("to_arvalid_drop", 32'(m.arvalid), 0);
        @(negedge clk);
        chk("to_arvalid_after", 32'(m.arvalid), 0);
        ar_never = 1'b0;
        txn(0, 32'h100, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("to_next_err", 32'(err), 0);
        chk("to_next_data", rd, model[8'h40]);
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // response stall
        rsp_ready = 1'b0;
        txn(0, 32'h40, 3'd2, 0, 0, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
        chk("stall_data", rd, model[8'h10]);
        hold = rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(q_rsp_valid), 1);
            chk("stall_rdata", q_rsp_rdata, hold);
            chk("stall_req_ready", 32'(q_req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(q_rsp_valid), 0);
        chk("stall_release_ready", 32'(q_req_ready), 1);

        // reset while waiting for a slow B
        b_dly = 30; h_w = w_hs; h_b = b_hs;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_size = 3'd2;
        req_wdata = 32'hC0FFEE01; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (w_hs == h_w && n < 100) begin
            @(negedge clk); n++;
        end
        chk("rstb_w_seen", 32'(w_hs - h_w), 1);
        mdl_write(32'h80, 32'hC0FFEE01, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstb_req_ready", 32'(q_req_ready), 1);
        chk("rstb_valids", 32'({m.awvalid, m.wvalid, m.arvalid}), 0);
        any_rsp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (q_rsp_valid) any_rsp = 1'b1;
            @(negedge clk);
        end
        chk("rstb_no_rsp", 32'(any_rsp), 0);
        chk("rstb_late_b_drained", b_hs - h_b, 1);
        b_dly = 0;

        // randomized mix against the model
        for (int k = 0; k < 30; k++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63)) << 2;
            wd = $urandom;
            st = 4'($urandom_range(1, 15));
            txn(we, a, 3'd2, wd, st, 0, rd, err, tmo, ar_r, rsp_at, aw_at, w_f);
            chk("rnd_err", 32'(err), 0);
            if (we) begin
                mdl_write(a, wd, st);
                chk("rnd_wr_rdata", rd, 0);
            end else begin
                chk("rnd_rd_data", rd, model[a[9:2]]);
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
